// File: rtl/aes_key_schedule.sv
// Iterative AES key expansion: one schedule word per clock into a word store,
// with the complete schedule readable afterwards as 128-bit round keys.
module aes_key_schedule #(
   parameter int Nk = 4,
   parameter int Nr = 10,
   localparam int Nkb = Nk * 32
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           start,
   input  logic [0:Nkb-1] key,
   output logic           busy,
   output logic           done,
   output logic           key_valid,
   input  logic [3:0]     rk_idx,
   output logic [0:127]   rk_out
);

   localparam int NW = 4 * (Nr + 1);
   localparam int IW = $clog2(NW);

   localparam logic [0:2047] SBOX = {
      128'h637c777bf26b6fc53001672bfed7ab76,
      128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115,
      128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84,
      128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8,
      128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973,
      128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479,
      128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
      128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df,
      128'h8ca1890dbfe6426841992d0fb054bb16
   };

   typedef enum logic {IDLE, EXPAND} state_t;

   state_t        state;
   logic [IW-1:0] i;
   logic [2:0]    mcnt;
   logic [7:0]    rcon;
   logic [31:0]   w [NW];
   logic [31:0]   prev_w;
   logic [31:0]   back_w;
   logic [31:0]   sub_in;
   logic [31:0]   sub_out;
   logic [31:0]   temp;
   logic [31:0]   next_w;

   function automatic logic [7:0] sbox(input logic [7:0] b);
      return SBOX[{b, 3'b000} +: 8];
   endfunction

   function automatic logic [31:0] subword(input logic [31:0] x);
      return {sbox(x[31:24]), sbox(x[23:16]), sbox(x[15:8]), sbox(x[7:0])};
   endfunction

   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   // mcnt == 0 marks i mod Nk == 0; for Nk == 8, mcnt == 4 marks i mod Nk == 4
   always_comb begin
      prev_w  = w[i - IW'(1)];
      back_w  = w[i - IW'(Nk)];
      sub_in  = (mcnt == 3'd0) ? {prev_w[23:0], prev_w[31:24]} : prev_w;
      sub_out = subword(sub_in);
      temp    = prev_w;
      if (mcnt == 3'd0)
         temp = sub_out ^ {rcon, 24'h0};
      else if (Nk == 8 && mcnt == 3'd4)
         temp = sub_out;
      next_w  = back_w ^ temp;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         busy      <= 1'b0;
         done      <= 1'b0;
         key_valid <= 1'b0;
         i         <= '0;
         rcon      <= '0;
         mcnt      <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  state     <= EXPAND;
                  busy      <= 1'b1;
                  key_valid <= 1'b0;
                  i         <= IW'(Nk);
                  rcon      <= 8'h01;
                  mcnt      <= '0;
               end
            end
            EXPAND: begin
               i    <= i + IW'(1);
               mcnt <= (mcnt == 3'd0) ? 3'(Nk - 1) : mcnt - 3'd1;
               if (mcnt == 3'd0)
                  rcon <= xtime(rcon);
               if (i == IW'(NW - 1)) begin
                  state     <= IDLE;
                  busy      <= 1'b0;
                  done      <= 1'b1;
                  key_valid <= 1'b1;
               end
            end
         endcase
      end
   end

   // Word store carries no reset: stale contents are hidden by key_valid
   always_ff @(posedge clk) begin
      if (state == IDLE && start) begin
         for (int k = 0; k < Nk; k++)
            w[IW'(k)] <= key[32*k +: 32];
      end else if (state == EXPAND) begin
         w[i] <= next_w;
      end
   end

   always_comb begin
      rk_out = '0;
      if (key_valid && rk_idx <= 4'(Nr)) begin
         for (int k = 0; k < 4; k++)
            rk_out[32*k +: 32] = w[IW'({rk_idx, 2'b00}) + IW'(k)];
      end
   end

endmodule

// File: tb/tb_aes_key_schedule.sv
// Bench for aes_key_schedule: AES-128/192/256 instances, a FIPS-197 style
// reference model and a scoreboard checked whenever a schedule completes.
module tb_aes_key_schedule;

   typedef struct packed {
      logic [1:0]    sel;
      logic [31:0]   due;
      logic          kat;
      logic [3:0]    ka_i;
      logic [127:0]  ka_v;
      logic [3:0]    kb_i;
      logic [127:0]  kb_v;
      logic [1919:0] rks;
   } exp_t;

   logic         clk = 1'b0;
   logic         rst;
   logic [2:0]   start_v;
   logic [255:0] key_bus;
   logic [3:0]   rk_idx;
   logic         busy_v [3];
   logic         done_v [3];
   logic         kv_v [3];
   logic [127:0] rk_v [3];

   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;
   logic [7:0] sbt [256];
   exp_t sbq [$];
   exp_t me;
   logic [1:0] msel;

   always #20 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   aes_key_schedule #(.Nk(4), .Nr(10)) dut128 (
      .clk(clk), .rst(rst), .start(start_v[0]), .key(key_bus[255 -: 128]),
      .busy(busy_v[0]), .done(done_v[0]), .key_valid(kv_v[0]),
      .rk_idx(rk_idx), .rk_out(rk_v[0]));

   aes_key_schedule #(.Nk(6), .Nr(12)) dut192 (
      .clk(clk), .rst(rst), .start(start_v[1]), .key(key_bus[255 -: 192]),
      .busy(busy_v[1]), .done(done_v[1]), .key_valid(kv_v[1]),
      .rk_idx(rk_idx), .rk_out(rk_v[1]));

   aes_key_schedule #(.Nk(8), .Nr(14)) dut256 (
      .clk(clk), .rst(rst), .start(start_v[2]), .key(key_bus),
      .busy(busy_v[2]), .done(done_v[2]), .key_valid(kv_v[2]),
      .rk_idx(rk_idx), .rk_out(rk_v[2]));

   task automatic chkv(input string nm, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, want %h", nm, act, exp);
      end
   endtask

   task automatic chki(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d, want %0d", nm, act, exp);
      end
   endtask

   // GF(2^8) product modulo x^8+x^4+x^3+x+1
   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] x;
      p = 8'h00;
      x = a;
      for (int n = 0; n < 8; n++) begin
         if (b[n]) p = p ^ x;
         x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
      end
      return p;
   endfunction

   function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
      logic [15:0] t;
      t = {b, b} << n;
      return t[15:8];
   endfunction

   // S-box from its definition: multiplicative inverse followed by the affine map
   task automatic build_sbox();
      logic [7:0] inv;
      for (int v = 0; v < 256; v++) begin
         inv = 8'h00;
         for (int c = 1; c < 256; c++)
            if (v != 0 && gmul(8'(v), 8'(c)) == 8'h01) inv = 8'(c);
         sbt[v] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
      end
   endtask

   function automatic logic [31:0] subw(input logic [31:0] x);
      return {sbt[x[31:24]], sbt[x[23:16]], sbt[x[15:8]], sbt[x[7:0]]};
   endfunction

   function automatic int nk_of(input logic [1:0] s);
      return (s == 2'd0) ? 4 : (s == 2'd1) ? 6 : 8;
   endfunction

   // Full schedule packed as round keys, rk0 in the top 128 bits
   function automatic logic [1919:0] model(input int nk, input logic [255:0] k);
      logic [31:0]   w [60];
      logic [31:0]   t;
      logic [7:0]    rc;
      logic [1919:0] r;
      int            nr;
      nr = nk + 6;
      rc = 8'h01;
      r  = '0;
      for (int n = 0; n < nk; n++) w[n] = k[255 - 32*n -: 32];
      for (int n = nk; n < 4 * (nr + 1); n++) begin
         t = w[n-1];
         if (n % nk == 0) begin
            t  = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
            rc = gmul(rc, 8'h02);
         end else if (nk > 6 && n % nk == 4) begin
            t = subw(t);
         end
         w[n] = w[n-nk] ^ t;
      end
      for (int rr = 0; rr <= nr; rr++)
         r[1919 - 128*rr -: 128] = {w[4*rr], w[4*rr+1], w[4*rr+2], w[4*rr+3]};
      return r;
   endfunction

   function automatic logic [255:0] rkey();
      return {$urandom(), $urandom(), $urandom(), $urandom(),
              $urandom(), $urandom(), $urandom(), $urandom()};
   endfunction

   // Called just after a rising edge; returns just after the accepting edge
   task automatic issue(input logic [1:0] s, input logic [255:0] k, input logic kat,
                        input logic [3:0] ai, input logic [127:0] av,
                        input logic [3:0] bi, input logic [127:0] bv);
      exp_t e;
      int   nk;
      nk = nk_of(s);
      e.sel  = s;
      e.kat  = kat;
      e.ka_i = ai;
      e.ka_v = av;
      e.kb_i = bi;
      e.kb_v = bv;
      e.rks  = model(nk, k);
      key_bus    = k;
      start_v    = 3'b000;
      start_v[s] = 1'b1;
      @(posedge clk);
      #1;
      e.due   = 32'(cyc + 4 * (nk + 7) - nk);
      sbq.push_back(e);
      start_v = 3'b000;
   endtask

   task automatic wait_done(input logic [1:0] s);
      int n;
      n = 0;
      while (done_v[s] !== 1'b1 && n < 200) begin
         @(posedge clk);
         #1;
         n++;
      end
      if (done_v[s] !== 1'b1) begin
         checks++;
         errors++;
         $display("FAIL wait_done: instance %0d gave no done within %0d cycles", s, n);
      end
   endtask

   // Monitor: pops the scoreboard on every done pulse and sweeps all rk_idx values
   always @(negedge clk) begin
      for (int si = 0; si < 3; si++) begin
         msel = 2'(si);
         if (done_v[msel] === 1'b1) begin
            if (sbq.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_done: instance %0d, none pending", si);
            end else begin
               me = sbq.pop_front();
               chki("done_sel", 32'(msel), 32'(me.sel));
               chki("done_latency", 32'(cyc), me.due);
               chki("busy_at_done", 32'(busy_v[msel]), 32'd0);
               chki("kv_at_done", 32'(kv_v[msel]), 32'd1);
               for (int x = 0; x < 16; x++) begin
                  rk_idx = 4'(x);
                  #1;
                  if (x <= nk_of(msel) + 6)
                     chkv("rk_sweep", rk_v[msel], me.rks[1919 - 128*x -: 128]);
                  else
                     chkv("rk_out_of_range", rk_v[msel], 128'h0);
               end
               if (me.kat) begin
                  rk_idx = me.ka_i;
                  #1;
                  chkv("kat_a", rk_v[msel], me.ka_v);
                  rk_idx = me.kb_i;
                  #1;
                  chkv("kat_b", rk_v[msel], me.kb_v);
               end
               rk_idx = 4'd0;
            end
         end
      end
   end

   initial begin
      logic [255:0] k;
      logic [1:0]   s;
      int           n;
      build_sbox();
      rst     = 1'b1;
      start_v = 3'b000;
      key_bus = '0;
      rk_idx  = 4'd0;
      repeat (3) @(posedge clk);
      #1;
      for (int si = 0; si < 3; si++) begin
         s = 2'(si);
         chki("rst_busy", 32'(busy_v[s]), 32'd0);
         chki("rst_done", 32'(done_v[s]), 32'd0);
         chki("rst_kv", 32'(kv_v[s]), 32'd0);
         chkv("rst_rk", rk_v[s], 128'h0);
      end
      rst = 1'b0;
      @(posedge clk);
      #1;

      issue(2'd0, {128'h000102030405060708090a0b0c0d0e0f, 128'h0}, 1'b1,
            4'd10, 128'h13111d7fe3944a17f307a78b4d2b30c5,
            4'd0, 128'h000102030405060708090a0b0c0d0e0f);
      wait_done(2'd0);
      issue(2'd0, {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0}, 1'b1,
            4'd1, 128'ha0fafe1788542cb123a339392a6c7605,
            4'd10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
      wait_done(2'd0);
      issue(2'd1, {192'h000102030405060708090a0b0c0d0e0f1011121314151617, 64'h0}, 1'b1,
            4'd12, 128'ha4970a331a78dc09c418c271e3a41d5d,
            4'd0, 128'h000102030405060708090a0b0c0d0e0f);
      wait_done(2'd1);
      issue(2'd2, 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f, 1'b1,
            4'd14, 128'h24fc79ccbf0979e9371ac23c6d68de36,
            4'd0, 128'h000102030405060708090a0b0c0d0e0f);
      wait_done(2'd2);

      // start and key disturbed while expanding
      issue(2'd0, rkey(), 1'b0, 4'd0, 128'h0, 4'd0, 128'h0);
      repeat (5) @(posedge clk);
      #1;
      start_v[0] = 1'b1;
      key_bus    = rkey();
      repeat (3) @(posedge clk);
      #1;
      chki("mid_busy", 32'(busy_v[0]), 32'd1);
      chki("mid_kv", 32'(kv_v[0]), 32'd0);
      start_v = 3'b000;
      key_bus = rkey();
      wait_done(2'd0);

      // reset in the middle of an expansion
      issue(2'd0, rkey(), 1'b0, 4'd0, 128'h0, 4'd0, 128'h0);
      repeat (19) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      chki("midrst_busy", 32'(busy_v[0]), 32'd0);
      chki("midrst_done", 32'(done_v[0]), 32'd0);
      chki("midrst_kv", 32'(kv_v[0]), 32'd0);
      chkv("midrst_rk", rk_v[0], 128'h0);
      if (sbq.size() > 0) void'(sbq.pop_back());
      rst = 1'b0;
      n = 0;
      repeat (60) begin
         @(posedge clk);
         #1;
         if (done_v[0] === 1'b1) n++;
      end
      chki("no_done_after_rst", 32'(n), 32'd0);
      issue(2'd0, {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0}, 1'b1,
            4'd1, 128'ha0fafe1788542cb123a339392a6c7605,
            4'd10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
      wait_done(2'd0);

      // back-to-back: new start accepted in the done cycle
      issue(2'd0, rkey(), 1'b0, 4'd0, 128'h0, 4'd0, 128'h0);
      chki("b2b_kv_drop", 32'(kv_v[0]), 32'd0);
      chki("b2b_busy", 32'(busy_v[0]), 32'd1);
      wait_done(2'd0);

      for (int r = 0; r < 12; r++) begin
         s = 2'($urandom_range(0, 2));
         k = rkey();
         issue(s, k, 1'b0, 4'd0, 128'h0, 4'd0, 128'h0);
         wait_done(s);
         if ($urandom_range(0, 1) == 1) begin
            repeat ($urandom_range(1, 3)) @(posedge clk);
            #1;
         end
      end

      repeat (2) @(posedge clk);
      #1;
      chki("sb_drain", 32'(sbq.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
